// File: rtl/misr_chk_pkg.sv
// Shared types and constants for the MISR signature checker.
package misr_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [63:0] DEFAULT_POLY = 64'h800000000000000D;

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: shift left, feed back XOR of tapped bits, fold in data.
module misr_reg
    import misr_chk_pkg::*;
#(
    parameter int               WIDTH = 64,
    parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] sig_q;

    // Load wins over step so a restart never folds in a stray word.
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (step) begin
            sig_d = {sig_q[WIDTH-2:0], ^(sig_q & POLY)} ^ din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= seed;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/misr_sig_checker.sv
// Compacts NWORDS input words into a MISR signature and compares it with exp_sig.
// Optional abort/aborted ports are enabled by defining MISR_CHK_ABORT_EN.
module misr_sig_checker
    import misr_chk_pkg::*;
#(
    parameter int               WIDTH  = 64,
    parameter int               NWORDS = 8,
    parameter logic [WIDTH-1:0] POLY   = DEFAULT_POLY[WIDTH-1:0],
    parameter logic [WIDTH-1:0] SEED   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] exp_sig,
`ifdef MISR_CHK_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic [WIDTH-1:0] sig,
    output logic [15:0]      count,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam logic [15:0] LAST_IDX = 16'(NWORDS - 1);

    state_e      state_d, state_q;
    logic [15:0] count_d, count_q;
    logic        pass_d, pass_q;
    logic        aborted_d, aborted_q;
    logic        abort_req;
    logic        start_run;
    logic        accept;

`ifdef MISR_CHK_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pass_d    = pass_q;
        aborted_d = aborted_q;
        start_run = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Abort takes the cycle; a word offered alongside it is dropped.
                if (abort_req) begin
                    state_d   = DONE;
                    pass_d    = 1'b0;
                    aborted_d = 1'b1;
                end else if (in_valid) begin
                    accept  = 1'b1;
                    count_d = count_q + 16'd1;
                    if (count_q == LAST_IDX) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                pass_d  = (sig == exp_sig);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (start_run) begin
            count_d   = '0;
            pass_d    = 1'b0;
            aborted_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pass_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pass_q    <= pass_d;
            aborted_q <= aborted_d;
        end
    end

    misr_reg #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .load (start_run),
        .step (accept),
        .din  (in_data),
        .sig  (sig)
    );

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN) || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign count    = count_q;

`ifdef MISR_CHK_ABORT_EN
    assign aborted = aborted_q;
`else
    logic unused_aborted;
    assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_misr_sig_checker.sv
// Directed bench: per-cycle vector table on an NWORDS=2 instance plus hand sequences.
module tb_misr_sig_checker;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [63:0] in_data, exp_sig;

    logic        rdy2, busy2, done2, pass2;
    logic [63:0] sig2;
    logic [15:0] cnt2;
    logic        rdy8, busy8, done8, pass8;
    logic [63:0] sig8;
    logic [15:0] cnt8;
`ifdef MISR_CHK_ABORT_EN
    logic        abort;
    logic        aborted2, aborted8;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    misr_sig_checker #(.WIDTH(64), .NWORDS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data), .exp_sig(exp_sig),
`ifdef MISR_CHK_ABORT_EN
        .abort(abort), .aborted(aborted2),
`endif
        .sig(sig2), .count(cnt2), .busy(busy2), .done(done2), .pass(pass2)
    );

    misr_sig_checker #(.WIDTH(64), .NWORDS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy8),
        .in_data(in_data), .exp_sig(exp_sig),
`ifdef MISR_CHK_ABORT_EN
        .abort(abort), .aborted(aborted8),
`endif
        .sig(sig8), .count(cnt8), .busy(busy8), .done(done8), .pass(pass8)
    );

    typedef struct {
        logic        rst, start, vld;
        logic [63:0] data, exp;
        logic [63:0] sig;
        logic [15:0] cnt;
        logic        busy, done, pass, rdy;
    } vec_t;

    vec_t vt [27];

    function automatic vec_t mk(logic r, logic s, logic v, logic [63:0] d, logic [63:0] e,
                                logic [63:0] sg, logic [15:0] c,
                                logic b, logic dn, logic p, logic rd);
        vec_t x;
        x.rst = r; x.start = s; x.vld = v; x.data = d; x.exp = e;
        x.sig = sg; x.cnt = c; x.busy = b; x.done = dn; x.pass = p; x.rdy = rd;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic s, input logic v, input logic [63:0] d);
        @(negedge clk);
        rst = r; start = s; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; exp_sig = 64'h3;
`ifdef MISR_CHK_ABORT_EN
        abort = 1'b0;
`endif
        //             rst start vld data  exp    sig    cnt busy done pass rdy
        vt[0]  = mk(1, 0, 0, 64'h0, 64'h3, 64'h0, 0, 0, 0, 0, 0); // reset
        vt[1]  = mk(1, 0, 0, 64'h0, 64'h3, 64'h0, 0, 0, 0, 0, 0);
        vt[2]  = mk(0, 0, 0, 64'h0, 64'h3, 64'h0, 0, 0, 0, 0, 0); // idle
        vt[3]  = mk(0, 1, 0, 64'h0, 64'h3, 64'h0, 0, 1, 0, 0, 1); // start
        vt[4]  = mk(0, 0, 1, 64'h1, 64'h3, 64'h1, 1, 1, 0, 0, 1);
        vt[5]  = mk(0, 0, 1, 64'h0, 64'h3, 64'h3, 2, 1, 0, 0, 0); // CHECK
        vt[6]  = mk(0, 0, 0, 64'h0, 64'h3, 64'h3, 2, 0, 1, 1, 0); // DONE
        vt[7]  = mk(0, 0, 0, 64'h0, 64'h3, 64'h3, 2, 0, 1, 1, 0); // hold
        vt[8]  = mk(0, 1, 0, 64'h0, 64'h3, 64'h0, 0, 1, 0, 0, 1); // restart
        vt[9]  = mk(0, 0, 1, 64'h1, 64'h3, 64'h1, 1, 1, 0, 0, 1);
        vt[10] = mk(0, 0, 0, 64'h5, 64'h3, 64'h1, 1, 1, 0, 0, 1); // stall
        vt[11] = mk(0, 0, 0, 64'h5, 64'h3, 64'h1, 1, 1, 0, 0, 1);
        vt[12] = mk(0, 0, 0, 64'h5, 64'h3, 64'h1, 1, 1, 0, 0, 1);
        vt[13] = mk(0, 0, 1, 64'h0, 64'h3, 64'h3, 2, 1, 0, 0, 0);
        vt[14] = mk(0, 0, 0, 64'h0, 64'h3, 64'h3, 2, 0, 1, 1, 0);
        vt[15] = mk(0, 1, 0, 64'h0, 64'h3, 64'h0, 0, 1, 0, 0, 1);
        vt[16] = mk(0, 1, 1, 64'h1, 64'h3, 64'h1, 1, 1, 0, 0, 1); // start ignored in RUN
        vt[17] = mk(0, 0, 1, 64'h0, 64'h3, 64'h3, 2, 1, 0, 0, 0);
        vt[18] = mk(0, 0, 0, 64'h0, 64'h5, 64'h3, 2, 0, 1, 0, 0); // mismatch
        vt[19] = mk(0, 1, 0, 64'h0, 64'h3, 64'h0, 0, 1, 0, 0, 1);
        vt[20] = mk(0, 0, 1, 64'h1, 64'h3, 64'h1, 1, 1, 0, 0, 1);
        vt[21] = mk(1, 0, 1, 64'h0, 64'h3, 64'h0, 0, 0, 0, 0, 0); // reset mid-run
        vt[22] = mk(0, 1, 0, 64'h0, 64'h3, 64'h0, 0, 1, 0, 0, 1);
        vt[23] = mk(0, 0, 1, 64'h1, 64'h3, 64'h1, 1, 1, 0, 0, 1);
        vt[24] = mk(0, 0, 1, 64'h0, 64'h3, 64'h3, 2, 1, 0, 0, 0);
        vt[25] = mk(0, 0, 0, 64'h0, 64'h3, 64'h3, 2, 0, 1, 1, 0);
        vt[26] = mk(1, 1, 1, 64'h7, 64'h3, 64'h0, 0, 0, 0, 0, 0); // rst beats start

        for (int i = 0; i < 27; i++) begin
            exp_sig = vt[i].exp;
            drive(vt[i].rst, vt[i].start, vt[i].vld, vt[i].data);
            chk($sformatf("v%0d.sig", i),  sig2,  vt[i].sig);
            chk($sformatf("v%0d.cnt", i),  64'(cnt2), 64'(vt[i].cnt));
            chk($sformatf("v%0d.busy", i), 64'(busy2), 64'(vt[i].busy));
            chk($sformatf("v%0d.done", i), 64'(done2), 64'(vt[i].done));
            chk($sformatf("v%0d.pass", i), 64'(pass2), 64'(vt[i].pass));
            chk($sformatf("v%0d.rdy", i),  64'(rdy2), 64'(vt[i].rdy));
        end

        // Eight all-zero words on the NWORDS=8 instance, exp_sig=1 -> pass=0.
        exp_sig = 64'h1;
        drive(1, 0, 0, 64'h0);
        drive(0, 1, 0, 64'h0);
        for (int i = 0; i < 7; i++) drive(0, 0, 1, 64'h0);
        chk("n8.cnt7", 64'(cnt8), 64'd7);
        chk("n8.rdy7", 64'(rdy8), 64'd1);
        drive(0, 0, 1, 64'h0);
        chk("n8.cnt8", 64'(cnt8), 64'd8);
        chk("n8.rdy_check", 64'(rdy8), 64'd0);
        chk("n8.busy_check", 64'(busy8), 64'd1);
        begin
            int waited = 0;
            while (!done8 && waited < 20) begin
                drive(0, 0, 0, 64'h0);
                waited++;
            end
            chk("n8.done_latency", 64'(waited), 64'd1);
        end
        chk("n8.done", 64'(done8), 64'd1);
        chk("n8.sig", sig8, 64'h0);
        chk("n8.pass", 64'(pass8), 64'd0);
        chk("n8.cnt_hold", 64'(cnt8), 64'd8);

`ifdef MISR_CHK_ABORT_EN
        exp_sig = 64'h3;
        drive(1, 0, 0, 64'h0);
        drive(0, 1, 0, 64'h0);
        drive(0, 0, 1, 64'h1);
        @(negedge clk);
        abort = 1'b1; in_valid = 1'b1; in_data = 64'h0;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("ab.done", 64'(done2), 64'd1);
        chk("ab.pass", 64'(pass2), 64'd0);
        chk("ab.aborted", 64'(aborted2), 64'd1);
        chk("ab.cnt", 64'(cnt2), 64'd1);
        chk("ab.sig", sig2, 64'h1);
        drive(0, 1, 0, 64'h0);
        chk("ab.cleared", 64'(aborted2), 64'd0);
        chk("ab.busy", 64'(busy2), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/misr_sig_checker.md
MISR_SIG_CHECKER -- requirements
Module: misr_sig_checker

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the data and signature width in bits.
REQ-002 Parameter NWORDS, default 8, SHALL set the number of words compacted per run; the legal range is 1 to 65535.
REQ-003 Parameter POLY, default 64'h800000000000000D, SHALL set the MISR feedback tap mask, WIDTH bits.
REQ-004 Parameter SEED, default 0, SHALL set the signature value loaded at run start, WIDTH bits.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 start  input  1  SHALL be a run-request pulse.
REQ-008 in_valid  input  1  SHALL indicate that the upstream word is valid.
REQ-009 in_ready  output  1  SHALL indicate that the block accepts a word this cycle.
REQ-010 in_data  input  WIDTH  SHALL carry the word from the upstream delay-line stage.
REQ-011 exp_sig  input  WIDTH  SHALL carry the expected signature, sampled in CHECK.
REQ-012 sig  output  WIDTH  SHALL carry the current signature register.
REQ-013 count  output  16  SHALL carry the number of words accepted in the current run.
REQ-014 busy  output  1  SHALL be high in RUN or CHECK.
REQ-015 done  output  1  SHALL be high in DONE.
REQ-016 pass  output  1  SHALL give the compare result, valid while done=1.

Function
REQ-017 The FSM SHALL have four states, IDLE, RUN, CHECK and DONE.
REQ-018 In IDLE, start=1 SHALL load sig<=SEED, count<=0, pass<=0 and move to RUN.
REQ-019 The block SHALL hold in_ready=1 only in RUN; a word is accepted when in_valid and in_ready are both 1.
REQ-020 Each accepted word SHALL update sig<={sig[WIDTH-2:0], ^(sig & POLY)} ^ in_data and increment count by 1.
REQ-021 The cycle that accepts word NWORDS (count==NWORDS-1 before the update) SHALL move the FSM to CHECK.
REQ-022 In RUN with in_valid=0, sig and count SHALL hold.
REQ-023 CHECK SHALL last exactly 1 cycle; it registers pass<=(sig==exp_sig) and moves to DONE.
REQ-024 DONE SHALL hold sig, count and pass.
REQ-025 In DONE, start=1 SHALL restart the run exactly as from IDLE (REQ-018).
REQ-026 start SHALL be ignored in RUN and CHECK.
REQ-027 Latency from the last accepted word to done=1 SHALL be 2 clock edges: edge 1 enters CHECK, edge 2 enters DONE.
REQ-028 With NWORDS=1, the first accepted word SHALL transition the FSM directly to CHECK.

Reset
REQ-029 rst=1 SHALL force IDLE, sig=SEED, count=0, pass=0, done=0, busy=0 and in_ready=0 at the next edge, from any state.
REQ-030 rst SHALL take priority over start, abort and any handshake in the same cycle.
REQ-031 A run interrupted by reset SHALL leave no residual state, and no done pulse SHALL be produced.

Configuration
REQ-032 With macro MISR_CHK_ABORT_EN defined, the block SHALL add an input abort (1 bit) and an output aborted (1 bit).
REQ-033 With MISR_CHK_ABORT_EN defined, abort=1 in RUN SHALL move the FSM to DONE with pass=0 and aborted=1; any word presented on that same cycle SHALL NOT be accepted.
REQ-034 With MISR_CHK_ABORT_EN defined, aborted SHALL clear on start or rst.
REQ-035 Without MISR_CHK_ABORT_EN, the abort and aborted ports SHALL NOT exist, and runs end only via NWORDS or rst.

Structure
REQ-036 Package misr_chk_pkg SHALL hold the FSM state enum (IDLE, RUN, CHECK, DONE) and the default POLY constant.
REQ-037 Sub-module misr_reg SHALL implement the signature register with seed load and step enable, parameterised by WIDTH and POLY.
REQ-038 The FSM, count and compare logic SHALL reside in misr_sig_checker.

Verification
REQ-039 Reset/idle: rst for 2 cycles, then idle -> sig=0, count=0, in_ready=0, done=0, busy=0.
REQ-040 NWORDS=2, SEED=0, words 64'h1 then 64'h0, exp_sig=64'h3 -> sig=64'h1 after word 1, sig=64'h3 after word 2, done=1 two edges later, pass=1.
REQ-041 NWORDS=8, SEED=0, in_valid=1 every cycle with all-zero data, exp_sig=64'h1 -> sig stays 0, count reaches 8, pass=0.
REQ-042 Stalls: same stimulus as REQ-040 with in_valid low for 3 cycles between the two words -> identical sig=64'h3, pass=1, done delayed by 3 cycles.
REQ-043 Reset mid-run: assert rst after 1 of 2 words is accepted, then start -> count restarts at 0 and the run completes with pass=1 on the REQ-040 stimulus.
REQ-044 MISR_CHK_ABORT_EN defined: abort=1 after 1 of 2 words -> next edge done=1, pass=0, aborted=1; a subsequent start clears aborted.
